// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole game controller.
package mole_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGap,
    StShow,
    StDone
  } state_e;

  localparam logic [15:0] LfsrSeed = 16'hACE1;
  // Taps 16/14/13/11 as a mask over bits [15:0]
  localparam logic [15:0] LfsrTaps = 16'hB400;

  // Wide enough for round counts well beyond one byte
  localparam int unsigned RoundW = 16;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'd0, inc};
    return sum[8] ? 8'hff : sum[7:0];
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit Fibonacci LFSR, advancing every cycle; supplies mole positions.
module mole_lfsr
  import mole_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LfsrTaps)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole controller: key conditioning, tick timing, round FSM and scoring.
// All visible outputs are registered so display sampling sees stable values.
module mole_game_ctrl
  import mole_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned SHOW_TICKS = 800,
  parameter int unsigned GAP_TICKS  = 300,
  parameter int unsigned ROUNDS     = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] key,
  output logic [7:0] led,
  output logic [7:0] score,
  output logic [7:0] miss,
  output logic       hit,
  output logic       game_over
);

  localparam int unsigned PrescW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MaxTicks = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int unsigned TickW    = $clog2(MaxTicks + 1);

  state_e              state_q, state_d;
  logic [7:0]          sync1_q, sync2_q, sync3_q, rise_q;
  logic [PrescW-1:0]   presc_q;
  logic [TickW-1:0]    tick_cnt_q;
  logic [RoundW-1:0]   round_q, round_d;
  logic [2:0]          pos_q, pos_d, new_pos;
  logic [7:0]          led_q, led_d, score_q, score_d, miss_q, miss_d;
  logic                hit_q, hit_d;
  logic [15:0]         lfsr;
  logic                unused_lfsr;

  logic       tick, gap_done, show_done, key_hit, wrong_key, last_round;
  logic       enter, clear, load_pos, do_hit, exit_show;
  logic [1:0] miss_inc;

  mole_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:3];

  // Two-flop synchronizer followed by a registered rising-edge detector
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      rise_q  <= '0;
    end else begin
      sync1_q <= key;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      rise_q  <= sync2_q & ~sync3_q;
    end
  end

  assign tick = (presc_q == PrescW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || enter) begin
      presc_q    <= '0;
      tick_cnt_q <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        tick_cnt_q <= tick_cnt_q + 1'b1;
      end
    end
  end

  assign gap_done   = tick && (tick_cnt_q == TickW'(GAP_TICKS - 1));
  assign show_done  = tick && (tick_cnt_q == TickW'(SHOW_TICKS - 1));
  assign key_hit    = rise_q[pos_q];
  assign wrong_key  = |(rise_q & ~(8'd1 << pos_q));
  assign last_round = (round_q == RoundW'(ROUNDS));
  // Never show the same hole twice in a row
  assign new_pos    = (lfsr[2:0] == pos_q) ? lfsr[2:0] + 3'd1 : lfsr[2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      led_q   <= '0;
      score_q <= '0;
      miss_q  <= '0;
      hit_q   <= 1'b0;
      round_q <= '0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      score_q <= score_d;
      miss_q  <= miss_d;
      hit_q   <= hit_d;
      round_q <= round_d;
      pos_q   <= pos_d;
    end
  end

  // Start from any state restarts the game and outranks a same-cycle hit
  always_comb begin
    state_d   = state_q;
    enter     = 1'b0;
    clear     = 1'b0;
    load_pos  = 1'b0;
    do_hit    = 1'b0;
    exit_show = 1'b0;
    miss_inc  = 2'd0;
    if (start) begin
      state_d = StGap;
      enter   = 1'b1;
      clear   = 1'b1;
    end else begin
      case (state_q)
        StGap: begin
          if (gap_done) begin
            state_d  = StShow;
            enter    = 1'b1;
            load_pos = 1'b1;
          end
        end
        StShow: begin
          if (key_hit) begin
            do_hit    = 1'b1;
            exit_show = 1'b1;
          end else begin
            miss_inc  = {1'b0, wrong_key} + {1'b0, show_done};
            exit_show = show_done;
          end
          if (exit_show) begin
            state_d = last_round ? StDone : StGap;
            enter   = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    led_d     = led_q;
    score_d   = score_q;
    miss_d    = sat_add8(miss_q, miss_inc);
    hit_d     = do_hit;
    round_d   = round_q;
    pos_d     = pos_q;
    game_over = (state_q == StDone);
    if (enter) begin
      led_d = (state_d == StShow) ? (8'd1 << new_pos) : 8'd0;
    end
    if (load_pos) begin
      pos_d   = new_pos;
      round_d = round_q + 1'b1;
    end
    if (do_hit) begin
      score_d = sat_add8(score_q, 2'd1);
    end
    if (clear) begin
      score_d = '0;
      miss_d  = '0;
      round_d = '0;
    end
  end

  assign led   = led_q;
  assign score = score_q;
  assign miss  = miss_q;
  assign hit   = hit_q;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Bench for mole_game_ctrl: directed scenarios with a hit scoreboard, plus a long run.
module tb_mole_game_ctrl;

  typedef struct {
    logic [7:0] score;
    logic [7:0] miss;
  } exp_t;

  logic       clk;
  logic       rst, start;
  logic [7:0] key, led, score, miss;
  logic       hit, game_over;

  logic       rst_l, start_l;
  logic [7:0] key_l, led_l, score_l, miss_l;
  logic       hit_l, game_over_l;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  logic [15:0] m_lfsr;
  logic [2:0]  prev_pos;

  mole_game_ctrl #(
    .TICK_DIV   (4),
    .SHOW_TICKS (5),
    .GAP_TICKS  (2),
    .ROUNDS     (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key       (key),
    .led       (led),
    .score     (score),
    .miss      (miss),
    .hit       (hit),
    .game_over (game_over)
  );

  mole_game_ctrl #(
    .TICK_DIV   (4),
    .SHOW_TICKS (5),
    .GAP_TICKS  (2),
    .ROUNDS     (1000)
  ) dut_long (
    .clk       (clk),
    .rst       (rst_l),
    .start     (start_l),
    .key       (key_l),
    .led       (led_l),
    .score     (score_l),
    .miss      (miss_l),
    .hit       (hit_l),
    .game_over (game_over_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: taps 16/14/13/11, seed ACE1, synchronous reset
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after GAP entry; returns the position shown once SHOW is entered.
  task automatic wait_show(output logic [2:0] p);
    logic [2:0] cand;
    for (int i = 0; i < 7; i++) begin
      step(1);
      check("gap_led_zero", led, 32'h0);
    end
    cand = m_lfsr[2:0];
    p = (cand == prev_pos) ? cand + 3'd1 : cand;
    step(1);
    check("show_led_onehot", led, 32'h1 << p);
    prev_pos = p;
  endtask

  // Scoreboard monitor: every hit pulse must match the next queued expectation
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (hit) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_hit: got hit with score %0d, expected no hit", score);
      end else begin
        e = exp_q.pop_front();
        check("sb_score", score, e.score);
        check("sb_miss", miss, e.miss);
        check("sb_led_cleared", led, 32'h0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] p;
    logic [7:0] seen, last_led;
    int w, repeats, bad_onehot, hits_l, timeouts;

    rst = 1'b1; start = 1'b0; key = '0;
    rst_l = 1'b1; start_l = 1'b0; key_l = '0;
    prev_pos = 3'd0;
    step(3);
    check("rst_led", led, 0);
    check("rst_score", score, 0);
    check("rst_miss", miss, 0);
    check("rst_hit", hit, 0);
    check("rst_game_over", game_over, 0);
    rst = 1'b0; rst_l = 1'b0;
    step(2);

    // Start: eight cycles of GAP then one mole
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_show(p);

    // Round 1: correct key, hit exactly three edges after first sampling
    exp_q.push_back('{score: 8'd1, miss: 8'd0});
    key = 8'd1 << p;
    step(3);
    check("hit_not_early", hit, 0);
    step(1);
    check("hit_latency", hit, 1);
    check("hit_led_zero", led, 0);
    key = '0;
    wait_show(p);

    // Round 2: wrong key alone, then wrong and correct together
    key = 8'd1 << (p + 3'd1);
    step(1);
    key = '0;
    step(3);
    check("wrong_miss", miss, 1);
    check("wrong_led_held", led, 32'h1 << p);
    check("wrong_score", score, 1);
    exp_q.push_back('{score: 8'd2, miss: 8'd1});
    key = (8'd1 << p) | (8'd1 << (p + 3'd1));
    step(4);
    check("both_miss_unchanged", miss, 1);
    key = '0;
    wait_show(p);

    // Round 3: restart mid-SHOW with score 2
    check("pre_restart_score", score, 2);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("restart_score", score, 0);
    check("restart_miss", miss, 0);
    check("restart_led", led, 0);

    // Three rounds with no key: three timeouts then DONE
    for (int r = 0; r < 3; r++) begin
      wait_show(p);
      step(19);
      check("timeout_led_held", led, 32'h1 << p);
      check("timeout_miss_before", miss, r);
      step(1);
      check("timeout_led_zero", led, 0);
      check("timeout_miss_after", miss, r + 1);
    end
    check("done_game_over", game_over, 1);
    check("done_score", score, 0);
    step(5);
    check("done_held", game_over, 1);
    check("done_led", led, 0);

    // Start from DONE, then reset mid-GAP with start and keys asserted
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("done_restart_go", game_over, 0);
    check("done_restart_miss", miss, 0);
    step(3);
    rst = 1'b1; start = 1'b1; key = 8'hff;
    step(1);
    rst = 1'b0; start = 1'b0; key = '0;
    check("midrst_led", led, 0);
    check("midrst_score", score, 0);
    check("midrst_miss", miss, 0);
    check("midrst_hit", hit, 0);
    check("midrst_game_over", game_over, 0);
    step(10);
    check("midrst_start_ignored", led, 0);
    check("sb_drained", exp_q.size(), 0);

    // Long run: 1000 rounds, always hitting the shown hole
    seen = '0; last_led = '0;
    repeats = 0; bad_onehot = 0; hits_l = 0; timeouts = 0;
    start_l = 1'b1;
    step(1);
    start_l = 1'b0;
    for (int r = 0; r < 1000; r++) begin
      w = 0;
      while (led_l == 8'd0 && w < 40) begin
        step(1);
        w++;
      end
      if (led_l == 8'd0) begin
        timeouts++;
        break;
      end
      if (!$onehot(led_l)) bad_onehot++;
      if (led_l == last_led) repeats++;
      seen = seen | led_l;
      last_led = led_l;
      key_l = led_l;
      step(1);
      key_l = '0;
      w = 0;
      while (!hit_l && w < 8) begin
        step(1);
        w++;
      end
      if (hit_l) hits_l++;
    end
    check("long_timeouts", timeouts, 0);
    check("long_hits", hits_l, 1000);
    check("long_repeats", repeats, 0);
    check("long_onehot", bad_onehot, 0);
    check("long_all_holes", seen, 8'hff);
    check("long_score_sat", score_l, 8'hff);
    check("long_miss", miss_l, 0);
    check("long_game_over", game_over_l, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
